// File: rtl/stopwatch_pkg.sv
// Shared types and sizing for the stopwatch time-keeping core and the downstream
// digits stage.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    SW_RUN   = 2'd0,
    SW_PAUSE = 2'd1,
    SW_ADJ   = 2'd2
  } sw_state_t;

  localparam int SW_W   = 6;
  localparam int SW_MAX = 59;

endpackage

// File: rtl/stopwatch_if.sv
// Control pulses and time outputs of the stopwatch core, bundled for the top level.
interface stopwatch_if
  import stopwatch_pkg::*;
#(
  parameter int W = SW_W
);

  logic         tick_1hz;
  logic         tick_adj;
  logic         pause_p;
  logic         clr_p;
  logic         adj;
  logic         sel;
  logic [W-1:0] minutes;
  logic [W-1:0] seconds;
  logic         running;
  logic         sec_wrap;

  modport master (
    output tick_1hz, tick_adj, pause_p, clr_p, adj, sel,
    input  minutes, seconds, running, sec_wrap
  );

  modport slave (
    input  tick_1hz, tick_adj, pause_p, clr_p, adj, sel,
    output minutes, seconds, running, sec_wrap
  );

endinterface

// File: rtl/stopwatch_mod_counter.sv
// One modulo-(MAX_VAL+1) time field with clear priority over increment.
module mod_counter
  import stopwatch_pkg::*;
#(
  parameter int W       = SW_W,
  parameter int MAX_VAL = SW_MAX
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] value,
  output logic         at_max
);

  assign at_max = (value == W'(MAX_VAL));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value <= '0;
    end else if (clr) begin
      value <= '0;
    end else if (inc) begin
      value <= at_max ? '0 : value + W'(1);
    end
  end

endmodule

// File: rtl/stopwatch_counter.sv
// Minutes/seconds stopwatch core: run/pause/adjust FSM, carry and sec_wrap logic.
// Define STOPWATCH_SAT_EN to hold at MAX:MAX instead of wrapping to 00:00 when running.
module stopwatch_counter
  import stopwatch_pkg::*;
#(
  parameter int W       = SW_W,
  parameter int MAX_VAL = SW_MAX
) (
  input  logic             clk,
  input  logic             rst_n,
  stopwatch_if.slave       bus
);

  sw_state_t    state, state_nxt;
  sw_state_t    ret, ret_nxt;
  logic         sec_max, min_max;
  logic         sec_inc, min_inc;
  logic         run_tick, adj_tick, hold;
  logic         sec_wrap_nxt, sec_wrap_q;
  logic [W-1:0] sec_val, min_val;

  assign run_tick = (state == SW_RUN) && bus.tick_1hz;
  assign adj_tick = (state == SW_ADJ) && bus.tick_adj;

`ifdef STOPWATCH_SAT_EN
  assign hold = sec_max && min_max;
`else
  assign hold = 1'b0;
`endif

  // Adjust mode touches only the selected field, so there is no carry there.
  assign sec_inc      = (run_tick && !hold) || (adj_tick && bus.sel);
  assign min_inc      = (run_tick && sec_max && !hold) || (adj_tick && !bus.sel);
  assign sec_wrap_nxt = run_tick && sec_max && !hold && !bus.clr_p;

  mod_counter #(.W(W), .MAX_VAL(MAX_VAL)) u_sec (
    .clk    (clk),
    .rst_n  (rst_n),
    .inc    (sec_inc),
    .clr    (bus.clr_p),
    .value  (sec_val),
    .at_max (sec_max)
  );

  mod_counter #(.W(W), .MAX_VAL(MAX_VAL)) u_min (
    .clk    (clk),
    .rst_n  (rst_n),
    .inc    (min_inc),
    .clr    (bus.clr_p),
    .value  (min_val),
    .at_max (min_max)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= SW_RUN;
      ret        <= SW_RUN;
      sec_wrap_q <= 1'b0;
    end else begin
      state      <= state_nxt;
      ret        <= ret_nxt;
      sec_wrap_q <= sec_wrap_nxt;
    end
  end

  // Entering adjust remembers where to go back to; adj wins over pause_p.
  always_comb begin
    state_nxt = state;
    ret_nxt   = ret;
    unique case (state)
      SW_RUN: begin
        if (bus.adj) begin
          state_nxt = SW_ADJ;
          ret_nxt   = SW_RUN;
        end else if (bus.pause_p) begin
          state_nxt = SW_PAUSE;
        end
      end
      SW_PAUSE: begin
        if (bus.adj) begin
          state_nxt = SW_ADJ;
          ret_nxt   = SW_PAUSE;
        end else if (bus.pause_p) begin
          state_nxt = SW_RUN;
        end
      end
      SW_ADJ: begin
        if (!bus.adj) begin
          state_nxt = ret;
        end
      end
      default: begin
        state_nxt = SW_RUN;
        ret_nxt   = SW_RUN;
      end
    endcase
  end

  assign bus.minutes  = min_val;
  assign bus.seconds  = sec_val;
  assign bus.running  = (state == SW_RUN);
  assign bus.sec_wrap = sec_wrap_q;

endmodule

// File: tb/tb_stopwatch_counter.sv
// Directed self-checking bench for stopwatch_counter with hand-computed expected times.
module tb_stopwatch_counter;

  logic clk;
  logic rst_n;
  int   check_count;
  int   fail_count;
  int   wrap_count;
  int   wrap_at;
  int   run_low;

  stopwatch_if bus ();

  stopwatch_counter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    check_count++;
    if (observed !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // Drive one cycle of pulses, then sample just after the capturing edge.
  task automatic applyStimulus(input logic t1, input logic ta, input logic pp, input logic cp);
    bus.tick_1hz = t1;
    bus.tick_adj = ta;
    bus.pause_p  = pp;
    bus.clr_p    = cp;
    @(posedge clk);
    #1;
    bus.tick_1hz = 1'b0;
    bus.tick_adj = 1'b0;
    bus.pause_p  = 1'b0;
    bus.clr_p    = 1'b0;
  endtask

  task automatic setTime(input int m, input int s);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    bus.adj = 1'b1;
    bus.sel = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < m; i++) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    bus.sel = 1'b1;
    for (int i = 0; i < s; i++) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    bus.adj = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    check_count  = 0;
    fail_count   = 0;
    bus.tick_1hz = 1'b0;
    bus.tick_adj = 1'b0;
    bus.pause_p  = 1'b0;
    bus.clr_p    = 1'b0;
    bus.adj      = 1'b0;
    bus.sel      = 1'b0;
    rst_n        = 1'b0;
    #2;
    checkOutput("reset_min", 32'(bus.minutes), 0);
    checkOutput("reset_sec", 32'(bus.seconds), 0);
    checkOutput("reset_running", 32'(bus.running), 1);
    checkOutput("reset_wrap", 32'(bus.sec_wrap), 0);
    #20;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 61 ticks from 00:00
    wrap_count = 0;
    wrap_at    = 0;
    run_low    = 0;
    for (int i = 1; i <= 61; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
      if (bus.sec_wrap) begin
        wrap_count++;
        wrap_at = i;
      end
      if (!bus.running) run_low++;
    end
    checkOutput("count61_min", 32'(bus.minutes), 1);
    checkOutput("count61_sec", 32'(bus.seconds), 1);
    checkOutput("count61_wrap_count", 32'(wrap_count), 1);
    checkOutput("count61_wrap_at", 32'(wrap_at), 60);
    checkOutput("count61_running_low", 32'(run_low), 0);

    // pause/resume at 00:05
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("clr_min", 32'(bus.minutes), 0);
    checkOutput("clr_sec", 32'(bus.seconds), 0);
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("pre_pause_sec", 32'(bus.seconds), 5);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("paused_running", 32'(bus.running), 0);
    for (int i = 0; i < 10; i++) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("paused_hold_sec", 32'(bus.seconds), 5);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("resumed_running", 32'(bus.running), 1);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("resume_sec", 32'(bus.seconds), 8);
    checkOutput("resume_min", 32'(bus.minutes), 0);

    // tick and pause together: tick counts, state pauses
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
    checkOutput("tick_pause_sec", 32'(bus.seconds), 9);
    checkOutput("tick_pause_running", 32'(bus.running), 0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);

    // adj rising with a tick in RUN: tick still counts
    bus.adj = 1'b1;
    bus.sel = 1'b1;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("adj_tick_sec", 32'(bus.seconds), 10);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("adj_ignores_tick", 32'(bus.seconds), 10);
    bus.adj = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("adj_exit_running", 32'(bus.running), 1);

    // 59:59 then one tick
    setTime(59, 59);
    checkOutput("preload_min", 32'(bus.minutes), 59);
    checkOutput("preload_sec", 32'(bus.seconds), 59);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
`ifdef STOPWATCH_SAT_EN
    checkOutput("full_tick_min", 32'(bus.minutes), 59);
    checkOutput("full_tick_sec", 32'(bus.seconds), 59);
    checkOutput("full_tick_wrap", 32'(bus.sec_wrap), 0);
`else
    checkOutput("full_tick_min", 32'(bus.minutes), 0);
    checkOutput("full_tick_sec", 32'(bus.seconds), 0);
    checkOutput("full_tick_wrap", 32'(bus.sec_wrap), 1);
`endif

    // clr_p with a 59:59 tick
    setTime(59, 59);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
    checkOutput("clr_full_min", 32'(bus.minutes), 0);
    checkOutput("clr_full_sec", 32'(bus.seconds), 0);
    checkOutput("clr_full_wrap", 32'(bus.sec_wrap), 0);

    // adjust from PAUSE at 02:10
    setTime(2, 10);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("pause_at_0210", 32'(bus.running), 0);
    bus.adj = 1'b1;
    bus.sel = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    wrap_count = 0;
    for (int i = 0; i < 52; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
      if (bus.sec_wrap) wrap_count++;
    end
    checkOutput("adj_sec_min", 32'(bus.minutes), 2);
    checkOutput("adj_sec_sec", 32'(bus.seconds), 2);
    checkOutput("adj_no_wrap", 32'(wrap_count), 0);
    bus.sel = 1'b0;
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("adj_min_min", 32'(bus.minutes), 5);
    checkOutput("adj_min_sec", 32'(bus.seconds), 2);
    bus.adj = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("ret_pause_running", 32'(bus.running), 0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("ret_pause_hold", 32'(bus.seconds), 2);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);

    // clr_p with a tick at 12:34 in RUN
    setTime(12, 34);
    checkOutput("preload_1234", 32'(bus.minutes), 12);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
    checkOutput("clr_tick_min", 32'(bus.minutes), 0);
    checkOutput("clr_tick_sec", 32'(bus.seconds), 0);
    checkOutput("clr_tick_running", 32'(bus.running), 1);

    // async reset between edges at 03:45
    setTime(3, 44);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("pre_rst_sec", 32'(bus.seconds), 45);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_rst_min", 32'(bus.minutes), 0);
    checkOutput("async_rst_sec", 32'(bus.seconds), 0);
    checkOutput("async_rst_running", 32'(bus.running), 1);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    $display("TB_RESULT checks=%0d failures=%0d", check_count, fail_count);
    $finish;
  end

endmodule

// File: doc/stopwatch_counter.md
# stopwatch_counter

Minutes/seconds time-keeping core of the Lab 3 stopwatch, sitting directly upstream of the `digits` binary-to-BCD stage. It advances a 6-bit seconds field and a 6-bit minutes field on a 1 Hz enable pulse, and supports pause/resume, clear and a per-field adjust mode. Both binary fields feed `digits` instances, so every output value stays within 0..59.

## Interface
- `W`, default 6: width of each time field.
- `MAX_VAL`, default 59: terminal count of each field. Must satisfy `MAX_VAL < 2**W`.

- `clk`  in  1  system clock; the single clock domain.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `tick_1hz`  in  1  one-cycle count-enable pulse.
- `tick_adj`  in  1  one-cycle adjust-rate pulse (2 Hz).
- `pause_p`  in  1  one-cycle debounced pulse that toggles run/pause.
- `clr_p`  in  1  one-cycle debounced pulse that clears both fields.
- `adj`  in  1  level; 1 selects adjust mode.
- `sel`  in  1  level; field to adjust: 0 = minutes, 1 = seconds.
- `minutes`  out  W  binary minutes, 0..MAX_VAL.
- `seconds`  out  W  binary seconds, 0..MAX_VAL.
- `running`  out  1  1 when the state is SW_RUN.
- `sec_wrap`  out  1  one-cycle pulse when seconds rolls over from MAX_VAL to 0 in SW_RUN.

## Operation
- States: SW_RUN, SW_PAUSE, SW_ADJ. A `ret` register holds the state to resume after adjust.
- Reset values: state = SW_RUN, `ret` = SW_RUN, `minutes` = 0, `seconds` = 0, `running` = 1, `sec_wrap` = 0.
- All action decode uses the registered state, not the next state.
- SW_RUN:
  - `tick_1hz` increments `seconds`.
  - When `seconds` == MAX_VAL, a tick sets `seconds` to 0, increments `minutes` and pulses `sec_wrap`.
  - When `minutes` == MAX_VAL and `seconds` == MAX_VAL, a tick wraps both fields to 0.
- SW_RUN + `pause_p` -> SW_PAUSE. SW_PAUSE + `pause_p` -> SW_RUN. SW_PAUSE ignores `tick_1hz`.
- `adj` = 1 in SW_RUN or SW_PAUSE -> SW_ADJ, and `ret` captures the current state.
- SW_ADJ:
  - `tick_1hz` and `pause_p` are ignored.
  - `tick_adj` increments the field chosen by `sel`; that field wraps MAX_VAL -> 0.
  - No carry into the other field, and no `sec_wrap` pulse.
- `adj` = 0 in SW_ADJ -> `ret`.
- `clr_p` in any state sets both fields to 0 on the next edge. It has priority over any increment in the same cycle and leaves the state unchanged.
- Values above MAX_VAL are never produced.

## Timing
- All outputs are registered. An event sampled at edge N is visible after edge N; latency is 1 cycle.
- `running` follows the state register with no additional latency.
- `pause_p` and `tick_1hz` in the same SW_RUN cycle: the tick is counted and the state becomes SW_PAUSE.
- `adj` rising in the same cycle as `tick_1hz` in SW_RUN: the tick is counted; adjust takes effect from the next cycle.
- `sel` changing mid-adjust takes effect on the next `tick_adj`.
- `clr_p` together with a 59:59 tick: the result is 00:00 and `sec_wrap` stays 0.
- `rst_n` assertion mid-operation forces the reset values immediately, independent of `clk`. Deassertion is synchronised externally.

## Configuration
- `STOPWATCH_SAT_EN` defined:
  - At `minutes` == MAX_VAL and `seconds` == MAX_VAL, `tick_1hz` in SW_RUN holds 59:59 and `sec_wrap` stays 0.
  - Adjust-mode wrap is unaffected.
- Not defined: the 59:59 tick wraps to 00:00 and pulses `sec_wrap`.

## Structure
- `stopwatch_pkg` holds:
  - `typedef enum logic [1:0] sw_state_t {SW_RUN, SW_PAUSE, SW_ADJ}`
  - localparams `SW_W` = 6 and `SW_MAX` = 59, shared with `digits`.
- Sub-module `mod_counter` implements one field: inputs `inc`, `clr`; outputs `value` and `at_max`. It is instantiated twice.
- Inside `stopwatch_counter`:
  - Carry, saturation and `sec_wrap` logic.
  - The state machine.
  - The `ret` register.

## Test plan
- Reset, then 61 `tick_1hz` pulses -> 01:01. `sec_wrap` pulses exactly once, on the 60th tick. `running` = 1 throughout.
- At 00:05, `pause_p`, then 10 ticks, then `pause_p`, then 3 ticks -> holds 00:05 while paused, ends at 00:08.
- Preload 59:59 via adjust, then 1 tick:
  - Macro off -> 00:00 with a `sec_wrap` pulse.
  - Macro on -> stays 59:59, no pulse.
- From SW_PAUSE at 02:10:
  - `adj` = 1, `sel` = 1, 52 `tick_adj` -> 02:02 with no minute carry.
  - `sel` = 0, 3 `tick_adj` -> 05:02.
  - `adj` = 0 -> returns to SW_PAUSE, `running` = 0.
- `clr_p` coincident with `tick_1hz` at 12:34 in SW_RUN -> 00:00 next cycle; state stays SW_RUN.
- `rst_n` low between clock edges during counting at 03:45 -> outputs read 00:00 and `running` = 1 before the next edge.
